// File: rtl/maxpool2x2_stream_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pool stage.
// Holds the default sample width, the FSM state encoding and a wide signed max helper.
package maxpool2x2_stream_pkg;

  localparam int DATA_W_DEF = 16;

  // Width of the generic compare.
  // Narrower samples are sign-extended into it, so one helper serves any DATA_W up to 64.
  localparam int MAX_CMP_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed two's-complement maximum of two sign-extended samples.
  function automatic logic signed [MAX_CMP_W-1:0] smax(
    input logic signed [MAX_CMP_W-1:0] a,
    input logic signed [MAX_CMP_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Valid/data sample stream used for both the conv-side input and the dense-side output.
interface maxpool2x2_stream_if
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                     valid;
  logic signed [DATA_W-1:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);

endinterface

// File: rtl/maxpool2x2_stream_pool_line_buffer.sv
// One-row buffer of horizontal pair maxima for the even row of each window row-pair.
// It has a synchronous write port and a read port whose address is registered.
// The read address is loaded one sample ahead, on the even column of the odd row.
// The entry is therefore ready when the matching odd column arrives.
module pool_line_buffer
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 74,
  parameter int AW     = 7
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]            raddr_q;
  logic [AW-1:0]            raddr_d;

  // Hold the read address until the next load, so gaps inside a window keep the entry selected.
  always_comb begin
    raddr_d = raddr_q;
    if (re) begin
      raddr_d = raddr;
    end
  end

  // Register the read address.
  always_ff @(posedge clk) begin
    raddr_q <= raddr_d;
  end

  // Synchronous write of the horizontal pair maximum.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool between the conv stage and the dense stage.
// Raster-order samples are reduced as follows:
//   even rows:            pairwise maxima go into a line buffer;
//   odd rows, even col:   the sample is held;
//   odd rows, odd col:    the held sample, the new sample and the buffered pair are combined
//                         into one registered output.
// A trailing odd column or row is consumed but never pooled.
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 148,
  parameter int IN_HEIGHT = 148,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pool_en,
  maxpool2x2_stream_if.slave        in_if,
  maxpool2x2_stream_if.master       out_if,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int CW     = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int AW     = (HALF_W    > 1) ? $clog2(HALF_W)    : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] HALF_W_C = CW'(HALF_W);

  // Signed max at the configured sample width.
  function automatic logic signed [DATA_W-1:0] dmax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return DATA_W'(smax(MAX_CMP_W'(a), MAX_CMP_W'(b)));
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] held_q, held_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     frame_done_q, frame_done_d;
  logic                     busy_q, busy_d;

  logic [CW-1:0]            col_half;
  logic signed [DATA_W-1:0] hmax;
  logic                     lb_we;
  logic                     lb_re;
  logic [AW-1:0]            lb_addr;
  logic signed [DATA_W-1:0] lb_rdata;

  // Horizontal pair maximum and line-buffer slot for the current column.
  always_comb begin
    col_half = col_q >> 1;
    lb_addr  = col_half[AW-1:0];
    hmax     = dmax(held_q, in_if.data);
  end

  // Frame sequencing, window bookkeeping and next output values.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    held_d       = held_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_re        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (pool_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!pool_en) begin
          // Abort: drop the partial frame without a completion pulse.
          state_d = ST_IDLE;
          col_d   = '0;
          row_d   = '0;
        end else if (in_if.valid) begin
          if (!col_q[0]) begin
            held_d = in_if.data;
            // Preload the buffered pair for the coming odd column.
            // The trailing column of an odd-width row has no pair, so it is skipped.
            if (row_q[0] && (col_half < HALF_W_C)) begin
              lb_re = 1'b1;
            end
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = dmax(lb_rdata, hmax);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // Control state and registered outputs; reset clears them all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // The held even-column sample needs no reset.
  // It is always rewritten before it is used.
  always_ff @(posedge clk) begin
    held_q <= held_d;
  end

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  ((HALF_W > 0) ? HALF_W : 1),
    .AW     (AW)
  ) u_line_buffer (
    .clk    (clk),
    .we     (lb_we),
    .waddr  (lb_addr),
    .wdata  (hmax),
    .re     (lb_re),
    .raddr  (lb_addr),
    .rdata  (lb_rdata)
  );

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream using a 4x4 instance (A) and a 5x5 instance (B).
// Both instances share the input stream. Each has its own pool_en.
// Expected outputs come from a 2D window-max model over the fed frame.
module tb_maxpool2x2_stream;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 pool_en_a, pool_en_b;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 fd_a, busy_a, fd_b, busy_b;

  maxpool2x2_stream_if #(.DATA_W(DW)) in_a ();
  maxpool2x2_stream_if #(.DATA_W(DW)) out_a ();
  maxpool2x2_stream_if #(.DATA_W(DW)) in_b ();
  maxpool2x2_stream_if #(.DATA_W(DW)) out_b ();

  assign in_a.valid = in_valid;
  assign in_a.data  = in_data;
  assign in_b.valid = in_valid;
  assign in_b.data  = in_data;

  maxpool2x2_stream #(.IN_WIDTH(4), .IN_HEIGHT(4), .DATA_W(DW)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .pool_en    (pool_en_a),
    .in_if      (in_a),
    .out_if     (out_a),
    .frame_done (fd_a),
    .busy       (busy_a)
  );

  maxpool2x2_stream #(.IN_WIDTH(5), .IN_HEIGHT(5), .DATA_W(DW)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .pool_en    (pool_en_b),
    .in_if      (in_b),
    .out_if     (out_b),
    .frame_done (fd_b),
    .busy       (busy_b)
  );

  int checks   = 0;
  int failures = 0;
  int frame_v    [64];
  int gap_before [64];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ov(input int sel);
    return sel ? int'(out_b.valid) : int'(out_a.valid);
  endfunction

  function automatic int od(input int sel);
    logic signed [DW-1:0] v;
    v = sel ? out_b.data : out_a.data;
    return int'(v);
  endfunction

  function automatic int fdn(input int sel);
    return sel ? int'(fd_b) : int'(fd_a);
  endfunction

  function automatic int bz(input int sel);
    return sel ? int'(busy_b) : int'(busy_a);
  endfunction

  // Sample k of a w x h frame completes a window when it sits on an odd row and an odd column.
  // Both must lie inside the floor-pooled area.
  function automatic int completes(input int w, input int h, input int k);
    int r, c;
    r = k / w;
    c = k % w;
    return ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) ? 1 : 0;
  endfunction

  function automatic int win_max(input int w, input int k);
    int r, c, m;
    r = k / w;
    c = k % w;
    m = frame_v[(r - 1) * w + c - 1];
    if (frame_v[(r - 1) * w + c] > m) m = frame_v[(r - 1) * w + c];
    if (frame_v[r * w + c - 1] > m)   m = frame_v[r * w + c - 1];
    if (frame_v[r * w + c] > m)       m = frame_v[r * w + c];
    return m;
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel != 0) pool_en_b = v;
    else          pool_en_a = v;
  endtask

  task automatic cycle(input logic v, input int d);
    in_valid = v;
    in_data  = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp(input int start, input int n);
    for (int i = 0; i < 64; i++) begin
      frame_v[i]    = (i < n) ? start + i : 0;
      gap_before[i] = 0;
    end
  endtask

  task automatic fill_random(input int n);
    logic signed [DW-1:0] t;
    for (int i = 0; i < 64; i++) begin
      t             = DW'($urandom);
      frame_v[i]    = (i < n) ? int'(t) : 0;
      gap_before[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    end
  endtask

  // Feed n_feed samples of a w x h frame into instance sel and check every cycle.
  // stop_kind: 0 = full frame, 1 = drop pool_en afterwards, 2 = pulse reset afterwards.
  task automatic run_frame(input int sel, input int w, input int h, input int n_feed,
                           input int stop_kind, input string name);
    int last, exp_v;
    set_en(sel, 1'b1);
    cycle(1'b0, 0);
    chk($sformatf("%s_busy_start", name), bz(sel), 1);
    for (int k = 0; k < n_feed; k++) begin
      for (int g = 0; g < gap_before[k]; g++) begin
        cycle(1'b0, 0);
        chk($sformatf("%s_gap_ov_k%0d", name, k), ov(sel), 0);
        chk($sformatf("%s_gap_fd_k%0d", name, k), fdn(sel), 0);
      end
      last  = (stop_kind == 0 && k == w * h - 1) ? 1 : 0;
      exp_v = completes(w, h, k);
      cycle(1'b1, frame_v[k]);
      chk($sformatf("%s_ov_k%0d", name, k), ov(sel), exp_v);
      if (exp_v != 0) chk($sformatf("%s_od_k%0d", name, k), od(sel), win_max(w, k));
      chk($sformatf("%s_fd_k%0d", name, k), fdn(sel), last);
      chk($sformatf("%s_busy_k%0d", name, k), bz(sel), 1 - last);
      chk($sformatf("%s_other_ov_k%0d", name, k), ov(1 - sel), 0);
    end
    if (stop_kind == 2) begin
      reset = 1'b0;
      cycle(1'b1, 77);
      reset = 1'b1;
    end else begin
      set_en(sel, 1'b0);
      cycle((stop_kind == 1) ? 1'b1 : 1'b0, 77);
    end
    set_en(sel, 1'b0);
    chk($sformatf("%s_end_ov", name), ov(sel), 0);
    chk($sformatf("%s_end_fd", name), fdn(sel), 0);
    chk($sformatf("%s_end_busy", name), bz(sel), 0);
    if (stop_kind != 0) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b1, 100 + i);
        chk($sformatf("%s_post_ov%0d", name, i), ov(sel), 0);
        chk($sformatf("%s_post_fd%0d", name, i), fdn(sel), 0);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    pool_en_a = 1'b0;
    pool_en_b = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ov%0d", s), ov(s), 0);
      chk($sformatf("rst_od%0d", s), od(s), 0);
      chk($sformatf("rst_fd%0d", s), fdn(s), 0);
      chk($sformatf("rst_busy%0d", s), bz(s), 0);
    end
    reset = 1'b1;
    cycle(1'b0, 0);

    fill_ramp(0, 16);
    run_frame(0, 4, 4, 16, 0, "ramp4");

    fill_ramp(-16, 16);
    run_frame(0, 4, 4, 16, 0, "neg4");

    fill_ramp(0, 25);
    run_frame(1, 5, 5, 25, 0, "ramp5");

    fill_ramp(0, 16);
    for (int k = 1; k < 16; k++) gap_before[k] = 1;
    gap_before[10] = 10;
    run_frame(0, 4, 4, 16, 0, "gaps4");

    fill_ramp(0, 16);
    run_frame(0, 4, 4, 7, 1, "abort4");
    run_frame(0, 4, 4, 16, 0, "reen4");

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, i);
      chk($sformatf("dis_ov_a%0d", i), ov(0), 0);
      chk($sformatf("dis_ov_b%0d", i), ov(1), 0);
    end

    fill_ramp(0, 16);
    run_frame(0, 4, 4, 11, 2, "rst4");
    run_frame(0, 4, 4, 16, 0, "afterrst4");

    for (int n = 0; n < 3; n++) begin
      fill_random(16);
      run_frame(0, 4, 4, 16, 0, $sformatf("rnd4_%0d", n));
      fill_random(25);
      run_frame(1, 5, 5, 25, 0, $sformatf("rnd5_%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
